// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg: shared state encoding and constants for the fetch sequencer.
package pc_fetch_ctrl_pkg;
    typedef enum logic [1:0] {BOOT, REQ, HOLD, FLUSH} state_t;
    localparam int INST_W = 32;
    localparam int PC_STEP = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0380;
endpackage

// File: rtl/pc_fetch_ctrl_pc_next_sel.sv
// pc_fetch_ctrl_pc_next_sel: next-PC priority mux (exception > redirect > +4 > hold).
// Optional PC_ALIGN_CHK_EN keeps redirect low bits so the top can flag misalignment.
module pc_fetch_ctrl_pc_next_sel
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEF_EXC_VECTOR)
) (
    input  logic              exc_valid,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              advance,
    input  logic [ADDR_W-1:0] pc,
    output logic              redirect,
    output logic [ADDR_W-1:0] next_pc
);
    logic [ADDR_W-1:0] target;
`ifdef PC_ALIGN_CHK_EN
    assign target = exc_valid ? EXC_VECTOR : redirect_pc;
`else
    assign target = exc_valid ? EXC_VECTOR : redirect_pc & ~ADDR_W'(3);
`endif
    assign redirect = exc_valid || redirect_valid;
    assign next_pc = redirect ? target : advance ? pc + ADDR_W'(PC_STEP) : pc;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC register, imem req/ack sequencer and one-entry decode buffer.
// Optional PC_ALIGN_CHK_EN adds inst_misalign and halts fetch on misaligned targets.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEF_EXC_VECTOR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              exc_valid,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_ce,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] pc_q
`ifdef PC_ALIGN_CHK_EN
    ,
    output logic              inst_misalign
`endif
);
    state_t state;
    logic [ADDR_W-1:0] flush_addr, next_pc;
    logic redirect, can_issue, capture, to_flush, halted, bad;

    pc_fetch_ctrl_pc_next_sel #(.ADDR_W(ADDR_W), .EXC_VECTOR(EXC_VECTOR)) u_next (
        .exc_valid(exc_valid),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .advance(capture),
        .pc(pc_q),
        .redirect(redirect),
        .next_pc(next_pc)
    );

    assign can_issue = !inst_valid || !stall_i;
    assign imem_req = (state == REQ && can_issue) || state == FLUSH;
    assign inst_ce = imem_req;
    assign imem_addr = state == FLUSH ? flush_addr : pc_q;
    assign capture = state == REQ && can_issue && imem_ack;
    // A request already on the bus cannot be withdrawn, so it is drained in FLUSH.
    assign to_flush = redirect && state == REQ && imem_req && !imem_ack;

`ifdef PC_ALIGN_CHK_EN
    // A misaligned target met while draining is reported once the old request completes.
    assign bad = next_pc[1:0] != 2'b00 &&
                 ((redirect && !to_flush && state != FLUSH) || (state == FLUSH && imem_ack));
    always_ff @(posedge clk) begin
        if (!rst) inst_misalign <= 1'b0;
        else if (bad) inst_misalign <= 1'b1;
        else if (redirect || capture || !stall_i) inst_misalign <= 1'b0;
    end
`else
    assign bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= BOOT;
            pc_q <= RESET_PC;
            flush_addr <= RESET_PC;
            inst_valid <= 1'b0;
            inst <= '0;
            inst_pc <= '0;
            halted <= 1'b0;
        end else begin
            pc_q <= next_pc;
            halted <= bad || (halted && !redirect);
            if (to_flush) flush_addr <= pc_q;
            if (bad) begin
                inst_valid <= 1'b1;
                inst <= '0;
                inst_pc <= next_pc;
            end else if (redirect) begin
                inst_valid <= 1'b0;
            end else if (capture) begin
                inst_valid <= 1'b1;
                inst <= imem_rdata;
                inst_pc <= pc_q;
            end else if (!stall_i) begin
                inst_valid <= 1'b0;
            end
            state <= bad ? HOLD :
                     state == BOOT ? REQ :
                     state == REQ ? (to_flush ? FLUSH : (!redirect && !can_issue) ? HOLD : REQ) :
                     state == HOLD ? ((redirect || (!stall_i && !halted)) ? REQ : HOLD) :
                     (imem_ack ? REQ : FLUSH);
        end
    end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed plan scenarios, then random stall/redirect/latency traffic
// scored against a program-order model of the instruction stream seen by decode.
module tb_pc_fetch_ctrl;
    logic        clk, rst, stall_i, redirect_valid, exc_valid, imem_ack;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, inst_ce, inst_valid;
    logic [31:0] imem_addr, inst, inst_pc, pc_q;

    int checks = 0, errors = 0, consumed = 0;
    int unsigned lat_min = 0, lat_max = 0;
    bit resp_on = 1, stray_ack = 0, sb_on = 0;
    logic [31:0] tgt_q[$];
    logic [31:0] exp_pc = 0;

    pc_fetch_ctrl dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .exc_valid(exc_valid), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_ce(inst_ce), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .pc_q(pc_q)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_req", imem_req, 0);
        chk("rst_ce", inst_ce, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_pc", pc_q, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
    endtask

    // imem responder with programmable latency; also checks that requests are never withdrawn
    initial begin
        int unsigned cnt = 0, lat = 0;
        logic prev_req = 0, prev_ack = 0, prev_rst = 0;
        logic [31:0] prev_addr = 0;
        imem_ack = 0;
        imem_rdata = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst && prev_rst && prev_req && !prev_ack) begin
                chk("req_held", imem_req, 1);
                chk("addr_stable", imem_addr, prev_addr);
            end
            if (!resp_on) begin
                imem_ack = stray_ack;
                imem_rdata = 32'hDEAD_BEEF;
                cnt = 0;
                lat = $urandom_range(lat_max, lat_min);
            end else if (imem_req) begin
                if (cnt >= lat) begin
                    imem_ack = 1;
                    imem_rdata = mem(imem_addr);
                    cnt = 0;
                    lat = $urandom_range(lat_max, lat_min);
                end else begin
                    imem_ack = 0;
                    cnt++;
                end
            end else begin
                imem_ack = 0;
                cnt = 0;
                lat = $urandom_range(lat_max, lat_min);
            end
            prev_req = imem_req;
            prev_ack = imem_ack;
            prev_addr = imem_addr;
            prev_rst = rst;
        end
    end

    // Scoreboard monitor: decode consumes when inst_valid && !stall_i; stream is program order
    initial forever begin
        @(negedge clk);
        #2;
        if (sb_on) begin
            if (inst_valid && !stall_i) begin
                chk("sb_inst_pc", inst_pc, exp_pc);
                chk("sb_inst", inst, mem(exp_pc));
                exp_pc += 32'd4;
                consumed++;
            end
            if (redirect_valid || exc_valid) begin
                checks++;
                if (tgt_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_target: got empty queue, expected a pending target");
                end else begin
                    exp_pc = tgt_q.pop_front();
                end
            end
        end
    end

    initial begin
        rst = 0;
        stall_i = 0;
        redirect_valid = 0;
        redirect_pc = 0;
        exc_valid = 0;
        repeat (2) @(negedge clk);
        chk_reset();
        rst = 1;
        @(negedge clk);
        chk("boot_req", imem_req, 1);
        chk("boot_addr", imem_addr, 0);
        chk("boot_valid", inst_valid, 0);
        @(negedge clk);
        chk("zw_valid", inst_valid, 1);
        chk("zw_inst_pc0", inst_pc, 0);
        chk("zw_inst0", inst, mem(0));
        chk("zw_addr4", imem_addr, 4);
        @(negedge clk);
        chk("zw_inst_pc4", inst_pc, 4);
        chk("zw_addr8", imem_addr, 8);
        @(negedge clk);
        chk("zw_inst_pc8", inst_pc, 8);
        chk("zw_pc_c", pc_q, 32'hC);
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_req", imem_req, 0);
            chk("stall_inst_pc", inst_pc, 8);
            chk("stall_inst", inst, mem(8));
            chk("stall_valid", inst_valid, 1);
        end
        stall_i = 0;
        lat_min = 3;
        lat_max = 3;
        @(negedge clk);
        chk("unstall_req", imem_req, 1);
        chk("unstall_addr", imem_addr, 32'hC);
        chk("unstall_valid", inst_valid, 0);
        redirect_valid = 1;
        redirect_pc = 32'h100;
        @(negedge clk);
        redirect_valid = 0;
        chk("flush_addr", imem_addr, 32'hC);
        chk("flush_pc", pc_q, 32'h100);
        chk("flush_valid", inst_valid, 0);
        @(negedge clk);
        chk("flush_addr2", imem_addr, 32'hC);
        @(negedge clk);
        chk("flush_addr3", imem_addr, 32'hC);
        lat_min = 0;
        lat_max = 0;
        @(negedge clk);
        chk("post_flush_addr", imem_addr, 32'h100);
        chk("post_flush_valid", inst_valid, 0);
        chk("post_flush_req", imem_req, 1);
        exc_valid = 1;
        redirect_valid = 1;
        redirect_pc = 32'h200;
        @(negedge clk);
        exc_valid = 0;
        redirect_valid = 0;
        chk("exc_pc", pc_q, 32'h380);
        chk("exc_valid_drop", inst_valid, 0);
        chk("exc_addr", imem_addr, 32'h380);
        @(negedge clk);
        chk("exc_inst_pc", inst_pc, 32'h380);
        chk("exc_inst", inst, mem(32'h380));
        redirect_valid = 1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 0;
        chk("wrap_pc_pre", pc_q, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_pc", pc_q, 0);
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap_inst", inst, mem(32'hFFFF_FFFC));
        lat_min = 3;
        lat_max = 3;
        @(negedge clk);
        chk("pre_rst_addr", imem_addr, 4);
        redirect_valid = 1;
        redirect_pc = 32'h40;
        @(negedge clk);
        chk("rstflush_addr", imem_addr, 4);
        chk("rstflush_pc", pc_q, 32'h40);
        redirect_valid = 0;
        rst = 0;
        @(negedge clk);
        chk_reset();
        rst = 1;
        resp_on = 0;
        stray_ack = 1;
        @(negedge clk);
        chk("stale_valid", inst_valid, 0);
        chk("stale_pc", pc_q, 0);
        chk("stale_req", imem_req, 1);
        chk("stale_addr", imem_addr, 0);
        stray_ack = 0;
        resp_on = 1;
        lat_min = 0;
        lat_max = 3;
        @(negedge clk);
        stall_i = 1;
        redirect_valid = 1;
        redirect_pc = 32'h1000;
        tgt_q.push_back(32'h1000);
        sb_on = 1;
        for (int i = 0; i < 800; i++) begin
            int unsigned r;
            @(negedge clk);
            r = $urandom_range(19, 0);
            stall_i = ($urandom_range(3, 0) == 0);
            exc_valid = (r == 0);
            redirect_valid = (r == 1) || (r == 2) || (r == 0 && $urandom_range(1, 0) == 1);
            redirect_pc = $urandom;
            if (exc_valid || redirect_valid)
                tgt_q.push_back(exc_valid ? 32'h380 : redirect_pc & ~32'h3);
        end
        @(negedge clk);
        stall_i = 0;
        exc_valid = 0;
        redirect_valid = 0;
        repeat (10) @(negedge clk);
        chk("progress", consumed >= 80, 1);
        chk("tgt_q_drained", tgt_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
